// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: function codes, FSM states and
// the bit positions of the registered flag vector.
package alu_pkg;

  localparam logic [2:0] FN_SUB_AB = 3'b000;
  localparam logic [2:0] FN_SUB_BA = 3'b001;
  localparam logic [2:0] FN_PASS_A = 3'b010;
  localparam logic [2:0] FN_PASS_B = 3'b011;
  localparam logic [2:0] FN_ADD    = 3'b100;
  localparam logic [2:0] FN_AND    = 3'b101;
  localparam logic [2:0] FN_XOR    = 3'b110;
  localparam logic [2:0] FN_MUL    = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLG_Z  = 0;
  localparam int FLG_N  = 1;
  localparam int FLG_CY = 2;
  localparam int FLG_V  = 3;
  localparam int NFLG   = 4;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle, W steps.
// The final step is exposed combinationally so the caller can register it directly.
module alu_mul_seq #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_done,
  output logic [2*W-1:0] o_prod
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]   r_a;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic           r_run;

  logic [W-1:0]   w_addend;
  logic [W:0]     w_sum;
  logic [2*W-1:0] w_next;

  // Multiplier lives in the low half of the accumulator and drains out as the
  // product shifts in from the top.
  always_comb begin
    w_addend = r_acc[0] ? r_a : '0;
    w_sum    = {1'b0, r_acc[2*W-1:W]} + {1'b0, w_addend};
    w_next   = {w_sum, r_acc[W-1:1]};
  end

  assign o_done = r_run && (r_cnt == CW'(W - 1));
  assign o_prod = w_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_a   <= i_a;
      r_acc <= {{W{1'b0}}, i_b};
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_acc <= w_next;
      r_cnt <= r_cnt + 1'b1;
      if (o_done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake on both sides; single-cycle
// functions finish at accept, multiply runs through the shift-add sequencer.
module alu_mc
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [2:0]   fn,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] C,
  output logic         Z,
  output logic         N,
  output logic         CY,
  output logic         V
);

  state_e r_state, w_state_nxt;

  logic [W-1:0]    r_c;
  logic [NFLG-1:0] r_flags;

  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_accept;
  logic            w_is_mul;
  logic            w_mul_start;
  logic            w_mul_done;
  logic [2*W-1:0]  w_mul_prod;
  logic            w_load_alu;
  logic            w_load_mul;

  logic [W:0]      w_alu_wide;
  logic [W-1:0]    w_alu_c;
  logic            w_alu_cy;
  logic            w_alu_v;
  logic [NFLG-1:0] w_alu_flags;
  logic [NFLG-1:0] w_mul_flags;

  assign w_is_mul    = (fn == FN_MUL);
  assign w_accept    = in_valid && w_in_ready;
  assign w_mul_start = w_accept && w_is_mul;
  assign w_load_alu  = w_accept && !w_is_mul;
  assign w_load_mul  = (r_state == ST_BUSY) && w_mul_done;

  alu_mul_seq #(.W(W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_mul_start),
    .i_a     (A),
    .i_b     (B),
    .o_done  (w_mul_done),
    .o_prod  (w_mul_prod)
  );

  // Single-cycle datapath; everything runs at W+1 bits so bit W is the carry/borrow.
  always_comb begin
    w_alu_wide = '0;
    w_alu_cy   = 1'b0;
    w_alu_v    = 1'b0;
    case (fn)
      FN_SUB_AB: begin
        w_alu_wide = {1'b0, A} - {1'b0, B};
        w_alu_cy   = w_alu_wide[W];
        w_alu_v    = (A[W-1] ^ B[W-1]) & (w_alu_wide[W-1] ^ A[W-1]);
      end
      FN_SUB_BA: begin
        w_alu_wide = {1'b0, B} - {1'b0, A};
        w_alu_cy   = w_alu_wide[W];
        w_alu_v    = (A[W-1] ^ B[W-1]) & (w_alu_wide[W-1] ^ B[W-1]);
      end
      FN_PASS_A: w_alu_wide = {1'b0, A};
      FN_PASS_B: w_alu_wide = {1'b0, B};
      FN_ADD: begin
        w_alu_wide = {1'b0, A} + {1'b0, B};
        w_alu_cy   = w_alu_wide[W];
        w_alu_v    = ~(A[W-1] ^ B[W-1]) & (w_alu_wide[W-1] ^ A[W-1]);
      end
      FN_AND:    w_alu_wide = {1'b0, A & B};
      FN_XOR:    w_alu_wide = {1'b0, A ^ B};
      FN_MUL:    w_alu_wide = '0;
    endcase
    w_alu_c = w_alu_wide[W-1:0];

    w_alu_flags         = '0;
    w_alu_flags[FLG_Z]  = (w_alu_c == '0);
    w_alu_flags[FLG_N]  = w_alu_c[W-1];
    w_alu_flags[FLG_CY] = w_alu_cy;
    w_alu_flags[FLG_V]  = w_alu_v;

    w_mul_flags         = '0;
    w_mul_flags[FLG_Z]  = (w_mul_prod[W-1:0] == '0);
    w_mul_flags[FLG_N]  = w_mul_prod[W-1];
    w_mul_flags[FLG_CY] = |w_mul_prod[2*W-1:W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_is_mul ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (w_mul_done) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) w_state_nxt = w_is_mul ? ST_BUSY : ST_DONE;
          else          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result registers only move on a single-cycle accept or the last multiply step,
  // so they stay frozen for the whole DONE window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c     <= '0;
      r_flags <= '0;
    end else if (w_load_alu) begin
      r_c     <= w_alu_c;
      r_flags <= w_alu_flags;
    end else if (w_load_mul) begin
      r_c     <= w_mul_prod[W-1:0];
      r_flags <= w_mul_flags;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign C         = r_c;
  assign Z         = r_flags[FLG_Z];
  assign N         = r_flags[FLG_N];
  assign CY        = r_flags[FLG_CY];
  assign V         = r_flags[FLG_V];

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (W=16): arithmetic reference model plus per-cycle compare.
module tb_alu_mc;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic [2:0]   fn;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] C;
  logic         Z, N, CY, V;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_mc #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .fn(fn), .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .Z(Z), .N(N), .CY(CY), .V(V)
  );

  typedef struct packed {
    logic [W-1:0] c;
    logic z, n, cy, v;
  } res_t;

  function automatic res_t ref_op(logic [2:0] f, logic [W-1:0] a, logic [W-1:0] b);
    res_t   r;
    longint ua, ub, full, sa, sb, sr;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    full = 0; sr = 0;
    r = '0;
    case (f)
      3'd0: begin full = ua - ub; r.cy = (ua < ub); sr = sa - sb; end
      3'd1: begin full = ub - ua; r.cy = (ub < ua); sr = sb - sa; end
      3'd2: full = ua;
      3'd3: full = ub;
      3'd4: begin full = ua + ub; r.cy = (full > 65535); sr = sa + sb; end
      3'd5: full = ua & ub;
      3'd6: full = ua ^ ub;
      3'd7: begin full = ua * ub; r.cy = ((full >> 16) != 0); end
    endcase
    if (f == 3'd0 || f == 3'd1 || f == 3'd4) r.v = (sr > 32767) || (sr < -32768);
    r.c = full[W-1:0];
    r.z = (r.c == 0);
    r.n = r.c[W-1];
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pending result becomes visible after 1 edge (single-cycle)
  // or W edges (multiply) following the accepting edge; held until consumed.
  bit   m_valid = 1'b0;
  int   m_cd    = 0;
  res_t m_out   = '0;
  res_t m_pend  = '0;
  bit   m_rdy;
  res_t m_tmp;

  always @(posedge clk) begin
    m_rdy = (m_cd == 0) && (!m_valid || out_ready);
    if (!rst_n) begin
      m_valid = 1'b0; m_cd = 0; m_out = '0; m_pend = '0;
    end else begin
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin m_valid = 1'b1; m_out = m_pend; end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (in_valid && m_rdy) begin
        m_tmp = ref_op(fn, A, B);
        if (fn == 3'd7) begin m_pend = m_tmp; m_cd = W; end
        else begin m_out = m_tmp; m_valid = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cmp_in_ready", 32'(in_ready), 32'((m_cd == 0) && (!m_valid || out_ready)));
      chk("cmp_C", 32'(C), 32'(m_out.c));
      chk("cmp_flags", {28'd0, Z, N, CY, V}, {28'd0, m_out.z, m_out.n, m_out.cy, m_out.v});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op and hold it until accepted; operands are scrambled afterwards.
  task automatic accept(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    in_valid = 1'b1; fn = f; A = a; B = b;
    n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
    step();
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); fn = 3'($urandom);
  endtask

  task automatic run_op(input string nm, input logic [2:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat);
    int lat;
    accept(f, a, b);
    lat = 1;
    while (!out_valid && lat < 64) begin
      chk({nm, "_busy_in_ready"}, 32'(in_ready), 32'd0);
      step();
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic chk_res(string nm, logic [W-1:0] c, logic z, logic n, logic cy, logic v);
    chk({nm, "_C"}, 32'(C), 32'(c));
    chk({nm, "_ZNCV"}, {28'd0, Z, N, CY, V}, {28'd0, z, n, cy, v});
  endtask

  logic [2:0]   s_fn [8] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2, 3'd3, 3'd4};
  logic [W-1:0] s_a  [8] = '{16'h8000, 16'h4000, 16'hF0F0, 16'hAAAA,
                             16'h0001, 16'h1357, 16'h0000, 16'h8000};
  logic [W-1:0] s_b  [8] = '{16'h0001, 16'h4000, 16'h3C3C, 16'h5555,
                             16'h8000, 16'h2468, 16'hBEEF, 16'h8000};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    res_t e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; fn = '0;
    step(); step();
    chk_en = 1'b1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk_res("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    run_op("sub_ab", 3'b000, 16'h0005, 16'h0007, 1);
    chk_res("sub_ab", 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0);

    run_op("add_ovf", 3'b100, 16'h7FFF, 16'h0001, 1);
    chk_res("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("add_cy", 3'b100, 16'hFFFF, 16'h0001, 1);
    chk_res("add_cy", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    run_op("mul1", 3'b111, 16'h0123, 16'h0010, W + 1);
    chk_res("mul1", 16'h1230, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("mul2", 3'b111, 16'h1000, 16'h0010, W + 1);
    chk_res("mul2", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    step();

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    run_op("bp_add", 3'b100, 16'h0003, 16'h0004, 1);
    held = C;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_C", 32'(C), 32'h0007);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_still_held", 32'(C), 32'(held));
    run_op("bp_sub_ba", 3'b001, 16'h1234, 16'h1234, 1);
    chk_res("bp_sub_ba", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the 5th BUSY cycle discards the multiply.
    accept(3'b111, 16'h00FF, 16'h0101);
    for (int i = 0; i < 4; i++) step();
    chk("rst_pre_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk_res("rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk("rst_after_ready", 32'(in_ready), 32'd1);
    run_op("xor", 3'b110, 16'hFF00, 16'h0FF0, 1);
    chk_res("xor", 16'hF0F0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Streaming: one single-cycle op per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; fn = s_fn[i]; A = s_a[i]; B = s_b[i];
      e = ref_op(s_fn[i], s_a[i], s_b[i]);
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("stream_out_valid", 32'(out_valid), 32'd1);
      chk("stream_C", 32'(C), 32'(e.c));
      chk("stream_flags", {28'd0, Z, N, CY, V}, {28'd0, e.z, e.n, e.cy, e.v});
    end
    in_valid = 1'b0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
